// File: rtl/shift_add_mult8.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier with valid/ready
// handshakes on operands and product; one add-stage iteration per clock.
module shift_add_mult8 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [WIDTH-1:0]     mcand_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   acc_s;
    logic [WIDTH:0]       sum_s;
    logic [CNT_W-1:0]     cnt_r;
    logic                 last_s;
    logic [2*WIDTH-1:0]   product_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 busy_r;

    // Add stage: carry-out plus WIDTH-bit sum, the carry is never dropped.
    function automatic logic [WIDTH:0] add_stage(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // One iteration: conditional add into the high half, then shift right with carry in.
    always_comb begin
        sum_s  = add_stage(acc_r[2*WIDTH-1:WIDTH],
                           acc_r[0] ? mcand_r : {WIDTH{1'b0}});
        acc_s  = {sum_s, acc_r[WIDTH-1:1]};
        last_s = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and registered handshake/status flags derived from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
        end
    end

    // Datapath: operand capture, iteration, and product hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r   <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        mcand_r <= a;
                        acc_r   <= {{WIDTH{1'b0}}, b};
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        mcand_r <= mcand_r;
                    end
                end
                CALC: begin
                    acc_r <= acc_s;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        product_r <= acc_s;
                    end else begin
                        product_r <= product_r;
                    end
                end
                DONE: begin
                    product_r <= product_r;
                end
                default: begin
                    product_r <= product_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign product   = product_r;

endmodule

// File: tb/tb_shift_add_mult8.sv
// Self-checking bench for shift_add_mult8: vector table, corner sequences,
// and a scoreboard queue fed at operand acceptance and drained at product handshake.
module tb_shift_add_mult8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int total;
    int bad;
    int cyc;
    logic [15:0] exp_q[$];
    int          pop_times[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    shift_add_mult8 #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Scoreboard: push at acceptance, pop/compare at output handshake, flush on reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) exp_q.push_back(16'(a * b));
            if (out_valid && out_ready) begin
                pop_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", {16'd0, product}, 32'hFFFF_FFFF);
                end else begin
                    check("sb_product", {16'd0, product}, {16'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic wait_accept(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({nm, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string nm, output int lat, output int busy_lo);
        lat = 0;
        busy_lo = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (!busy) busy_lo = busy_lo + 1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) check({nm, "_out_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic [7:0] aa, input logic [7:0] bb,
                         input logic [15:0] exp, input string nm, input bit full);
        int lat;
        int blo;
        a = aa;
        b = bb;
        in_valid = 1'b1;
        out_ready = 1'b1;
        wait_accept(nm);
        in_valid = 1'b0;
        a = ~aa;
        b = ~bb;
        wait_out(nm, lat, blo);
        check({nm, "_product"}, {16'd0, product}, {16'd0, exp});
        if (full) begin
            check({nm, "_latency"}, lat, 32'd8);
            check({nm, "_busy_low_cycles"}, blo, 32'd0);
        end
        @(posedge clk);
        #1;
        if (full) begin
            check({nm, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
            check({nm, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
            check({nm, "_product_retained"}, {16'd0, product}, {16'd0, exp});
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int blo;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] pa[3];
        logic [7:0] pb[3];

        total = 0;
        bad = 0;
        cyc = 0;
        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{8'd255, 8'd1,   16'h00FF};
        vecs[3] = '{8'd1,   8'd255, 16'h00FF};
        vecs[4] = '{8'd0,   8'd200, 16'd0};
        vecs[5] = '{8'd200, 8'd0,   16'd0};
        vecs[6] = '{8'd170, 8'd85,  16'd14450};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 8'd0;
        b = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_product", {16'd0, product}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i), 1'b1);
        end

        // Backpressure with an ignored operand offer during the stall.
        a = 8'd17;
        b = 8'd15;
        in_valid = 1'b1;
        out_ready = 1'b0;
        wait_accept("bp");
        in_valid = 1'b0;
        wait_out("bp", lat, blo);
        check("bp_latency", lat, 32'd8);
        for (int s = 0; s < 5; s++) begin
            a = 8'd3;
            b = 8'd3;
            in_valid = 1'b1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_product", {16'd0, product}, 32'd255);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("bp_product_end", {16'd0, product}, 32'd255);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_out_valid_after", {31'd0, out_valid}, 32'd0);
        check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
        check("bp_busy_after", {31'd0, busy}, 32'd0);

        // Asynchronous reset during iteration 4.
        a = 8'd100;
        b = 8'd100;
        in_valid = 1'b1;
        wait_accept("rst");
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready_after", {31'd0, in_ready}, 32'd1);
        repeat (12) @(posedge clk);
        #1;
        check("rst_no_stale_output", {31'd0, out_valid}, 32'd0);
        do_op(8'd100, 8'd100, 16'h2710, "post_rst", 1'b1);

        // Back-to-back with in_valid and out_ready held high.
        pa[0] = 8'd7;   pb[0] = 8'd9;
        pa[1] = 8'd128; pb[1] = 8'd2;
        pa[2] = 8'd255; pb[2] = 8'd254;
        pop_times.delete();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = pa[i];
            b = pb[i];
            wait_accept("b2b");
        end
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("b2b_outputs", pop_times.size(), 32'd3);
        if (pop_times.size() == 3) begin
            check("b2b_spacing01", pop_times[1] - pop_times[0], 32'd10);
            check("b2b_spacing12", pop_times[2] - pop_times[1], 32'd10);
        end
        check("b2b_last_product", {16'd0, product}, 32'd64770);

        // Random sweep against a*b.
        for (int r = 0; r < 1000; r++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op(ra, rb, 16'(ra * rb), "rand", 1'b0);
        end

        repeat (2) @(posedge clk);
        check("sb_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
